// File: rtl/sha256_msg_schedule.sv
// rtl/sha256_msg_schedule.sv - SHA-256 message-schedule generator streaming (Wj, Kj) beats
//
// Purpose:
//   Accepts one 512-bit padded message block and streams the 64 schedule
//   words Wj with their round constants Kj, one beat per handshake. The
//   schedule is produced from a 16-word sliding window: win[0] is always the
//   current Wj and each transfer shifts the window down by one word while the
//   next word is computed into win[15].
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   blk_valid  in   message block valid
//   blk_ready  out  block accepted when blk_valid && blk_ready (high in IDLE)
//   blk_data   in   512-bit block, word 0 = bits [511:480], big-endian words
//   w_valid    out  schedule beat valid
//   w_ready    in   consumer ready; beat transfers when w_valid && w_ready
//   w_out      out  schedule word Wj (0 when w_valid=0)
//   k_out      out  round constant Kj (0 when w_valid=0)
//   w_idx      out  round index j (0 when w_valid=0)
//   w_last     out  high with the j=63 beat
//   busy       out  high while a block is being streamed

module sha256_msg_schedule #(
  parameter int WORDSIZE = 32,
  parameter int ROUNDS   = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  blk_valid,
  output logic                  blk_ready,
  input  logic [16*WORDSIZE-1:0] blk_data,
  output logic                  w_valid,
  input  logic                  w_ready,
  output logic [WORDSIZE-1:0]   w_out,
  output logic [WORDSIZE-1:0]   k_out,
  output logic [5:0]            w_idx,
  output logic                  w_last,
  output logic                  busy
);

  localparam logic [5:0] LAST_IDX = 6'(ROUNDS - 1);

  typedef enum logic {IDLE, RUN} state_e;

  state_e              state_q, state_d;
  logic [5:0]          idx_q, idx_d;
  logic [WORDSIZE-1:0] win_q [16];
  logic [WORDSIZE-1:0] win_d [16];
  logic [WORDSIZE-1:0] w_next;
  logic                run;

  function automatic logic [31:0] sigma0(input logic [31:0] x);
    sigma0 = {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] sigma1(input logic [31:0] x);
    sigma1 = {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

  function automatic logic [31:0] k_rom(input logic [5:0] j);
    k_rom = 32'h0;
    case (j)
      6'd0:  k_rom = 32'h428a2f98; 6'd1:  k_rom = 32'h71374491;
      6'd2:  k_rom = 32'hb5c0fbcf; 6'd3:  k_rom = 32'he9b5dba5;
      6'd4:  k_rom = 32'h3956c25b; 6'd5:  k_rom = 32'h59f111f1;
      6'd6:  k_rom = 32'h923f82a4; 6'd7:  k_rom = 32'hab1c5ed5;
      6'd8:  k_rom = 32'hd807aa98; 6'd9:  k_rom = 32'h12835b01;
      6'd10: k_rom = 32'h243185be; 6'd11: k_rom = 32'h550c7dc3;
      6'd12: k_rom = 32'h72be5d74; 6'd13: k_rom = 32'h80deb1fe;
      6'd14: k_rom = 32'h9bdc06a7; 6'd15: k_rom = 32'hc19bf174;
      6'd16: k_rom = 32'he49b69c1; 6'd17: k_rom = 32'hefbe4786;
      6'd18: k_rom = 32'h0fc19dc6; 6'd19: k_rom = 32'h240ca1cc;
      6'd20: k_rom = 32'h2de92c6f; 6'd21: k_rom = 32'h4a7484aa;
      6'd22: k_rom = 32'h5cb0a9dc; 6'd23: k_rom = 32'h76f988da;
      6'd24: k_rom = 32'h983e5152; 6'd25: k_rom = 32'ha831c66d;
      6'd26: k_rom = 32'hb00327c8; 6'd27: k_rom = 32'hbf597fc7;
      6'd28: k_rom = 32'hc6e00bf3; 6'd29: k_rom = 32'hd5a79147;
      6'd30: k_rom = 32'h06ca6351; 6'd31: k_rom = 32'h14292967;
      6'd32: k_rom = 32'h27b70a85; 6'd33: k_rom = 32'h2e1b2138;
      6'd34: k_rom = 32'h4d2c6dfc; 6'd35: k_rom = 32'h53380d13;
      6'd36: k_rom = 32'h650a7354; 6'd37: k_rom = 32'h766a0abb;
      6'd38: k_rom = 32'h81c2c92e; 6'd39: k_rom = 32'h92722c85;
      6'd40: k_rom = 32'ha2bfe8a1; 6'd41: k_rom = 32'ha81a664b;
      6'd42: k_rom = 32'hc24b8b70; 6'd43: k_rom = 32'hc76c51a3;
      6'd44: k_rom = 32'hd192e819; 6'd45: k_rom = 32'hd6990624;
      6'd46: k_rom = 32'hf40e3585; 6'd47: k_rom = 32'h106aa070;
      6'd48: k_rom = 32'h19a4c116; 6'd49: k_rom = 32'h1e376c08;
      6'd50: k_rom = 32'h2748774c; 6'd51: k_rom = 32'h34b0bcb5;
      6'd52: k_rom = 32'h391c0cb3; 6'd53: k_rom = 32'h4ed8aa4a;
      6'd54: k_rom = 32'h5b9cca4f; 6'd55: k_rom = 32'h682e6ff3;
      6'd56: k_rom = 32'h748f82ee; 6'd57: k_rom = 32'h78a5636f;
      6'd58: k_rom = 32'h84c87814; 6'd59: k_rom = 32'h8cc70208;
      6'd60: k_rom = 32'h90befffa; 6'd61: k_rom = 32'ha4506ceb;
      6'd62: k_rom = 32'hbef9a3f7; 6'd63: k_rom = 32'hc67178f2;
      default: k_rom = 32'h0;
    endcase
  endfunction

  // W[j+16] in window terms: W[j+14]=win[14], W[j+9]=win[9], W[j+1]=win[1], W[j]=win[0].
  assign w_next = sigma1(win_q[14]) + win_q[9] + sigma0(win_q[1]) + win_q[0];

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    win_d   = win_q;
    case (state_q)
      IDLE: begin
        if (blk_valid) begin
          for (int i = 0; i < 16; i++) begin
            win_d[i] = blk_data[(15-i)*WORDSIZE +: WORDSIZE];
          end
          idx_d   = 6'd0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (w_ready) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = 6'd0;
            state_d = IDLE;
          end else begin
            for (int i = 0; i < 15; i++) begin
              win_d[i] = win_q[i+1];
            end
            win_d[15] = w_next;
            idx_d     = idx_q + 6'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= 6'd0;
      for (int i = 0; i < 16; i++) begin
        win_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      for (int i = 0; i < 16; i++) begin
        win_q[i] <= win_d[i];
      end
    end
  end

  // Every output is decoded from registered state only; beat fields are
  // gated to zero outside RUN so idle outputs are deterministic.
  assign run       = (state_q == RUN);
  assign blk_ready = ~run;
  assign w_valid   = run;
  assign busy      = run;
  assign w_out     = run ? win_q[0] : '0;
  assign k_out     = run ? k_rom(idx_q) : '0;
  assign w_idx     = run ? idx_q : 6'd0;
  assign w_last    = run && (idx_q == LAST_IDX);

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// tb/tb_sha256_msg_schedule.sv - directed self-checking bench for sha256_msg_schedule

module tb_sha256_msg_schedule;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk_data;
  logic         w_valid;
  logic         w_ready;
  logic [31:0]  w_out;
  logic [31:0]  k_out;
  logic [5:0]   w_idx;
  logic         w_last;
  logic         busy;

  int tests = 0;
  int fails = 0;
  int nbeats;

  logic [31:0] gold  [64];
  logic [31:0] cap_w [64];
  logic [31:0] cap_k [64];
  logic        cap_l [64];

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  sha256_msg_schedule #(.WORDSIZE(32), .ROUNDS(64)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_data  (blk_data),
    .w_valid   (w_valid),
    .w_ready   (w_ready),
    .w_out     (w_out),
    .k_out     (k_out),
    .w_idx     (w_idx),
    .w_last    (w_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    rotr = (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ss0(input logic [31:0] x);
    ss0 = rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ss1(input logic [31:0] x);
    ss1 = rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  task automatic make_gold(input logic [511:0] blk);
    for (int t = 0; t < 16; t++) gold[t] = blk[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++) gold[t] = ss1(gold[t-2]) + gold[t-7] + ss0(gold[t-15]) + gold[t-16];
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_idle_outs"}, {64'h0, w_valid, busy, w_idx}, 72'h0);
    chk({tag, "_idle_wk"}, {8'h0, w_out, k_out}, 72'h0);
    chk({tag, "_idle_last"}, w_last, 0);
    chk({tag, "_idle_rdy"}, blk_ready, 1);
  endtask

  // mode 0: always ready; mode 1: 5-cycle stall at j=20 then random ready.
  task automatic stream(input int mode, input int stop_at, input string nm);
    int got, cyc, hold, f0;
    logic r, stalled;
    logic [70:0] snap;
    got = 0; cyc = 0; hold = 0; stalled = 1'b0; snap = '0; f0 = fails;
    while (got < stop_at && cyc < 2000 && fails < f0 + 20) begin
      if (stalled) chk({nm, "_frozen"}, {w_out, k_out, w_idx, w_last}, snap);
      chk({nm, "_valid"}, {w_valid, busy, blk_ready}, 3'b110);
      chk({nm, "_idx"}, w_idx, got);
      chk({nm, "_w"}, w_out, gold[got]);
      chk({nm, "_k"}, k_out, KT[got]);
      chk({nm, "_last"}, w_last, (got == 63));
      cap_w[got] = w_out;
      cap_k[got] = k_out;
      cap_l[got] = w_last;
      if (mode == 0) r = 1'b1;
      else if (got == 20 && hold < 5) begin r = 1'b0; hold++; end
      else if (got > 20) r = 1'($urandom_range(0, 1));
      else r = 1'b1;
      w_ready = r;
      stalled = !r;
      snap = {w_out, k_out, w_idx, w_last};
      step();
      cyc++;
      if (r) got++;
    end
    if (got < stop_at) chk({nm, "_timeout"}, got, stop_at);
    nbeats = cyc;
    w_ready = 1'b1;
  endtask

  task automatic load(input logic [511:0] blk);
    blk_data  = blk;
    blk_valid = 1'b1;
    step();
    blk_valid = 1'b0;
  endtask

  logic [511:0] abc_blk, ff_blk, b_blk;

  initial begin
    abc_blk = {32'h61626380, 448'h0, 32'h00000018};
    ff_blk  = {512{1'b1}};
    for (int i = 0; i < 16; i++) b_blk[511 - 32*i -: 32] = 32'h9e3779b9 * (i + 1) + 32'h13;
    rst_n = 1'b0; blk_valid = 1'b0; blk_data = '0; w_ready = 1'b1;

    // Reset state
    #2;
    chk_idle("reset");
    step(); step();
    chk_idle("reset_clk");
    rst_n = 1'b1;

    // Test 1: "abc" block, full throughput
    make_gold(abc_blk);
    load(abc_blk);
    stream(0, 64, "abc");
    chk("abc_j0_w", cap_w[0], 32'h61626380);
    chk("abc_j0_k", cap_k[0], 32'h428a2f98);
    chk("abc_j16_w", cap_w[16], 32'h61626380);
    chk("abc_j17_w", cap_w[17], 32'h000f0000);
    chk("abc_j63_last", cap_l[63], 1);
    chk("abc_j63_k", cap_k[63], 32'hc67178f2);
    chk("abc_cycles", nbeats, 64);
    chk_idle("abc_after");

    // Test 2: all-ones block, modular wrap
    make_gold(ff_blk);
    load(ff_blk);
    stream(0, 64, "ff");
    chk("ff_j0_w", cap_w[0], 32'hffffffff);
    chk("ff_j16_w", cap_w[16], 32'h203ffffc);
    chk_idle("ff_after");

    // Test 3: backpressure
    make_gold(abc_blk);
    load(abc_blk);
    stream(1, 64, "bp");
    chk("bp_j17_w", cap_w[17], 32'h000f0000);
    chk("bp_j63_k", cap_k[63], 32'hc67178f2);
    chk_idle("bp_after");

    // Test 4: blk_valid held with two queued blocks
    make_gold(abc_blk);
    blk_data = abc_blk;
    blk_valid = 1'b1;
    step();
    blk_data = b_blk;
    stream(0, 64, "q1");
    chk("q1_gap_rdy", {blk_ready, w_valid}, 2'b10);
    step();
    blk_valid = 1'b0;
    make_gold(b_blk);
    stream(0, 64, "q2");
    chk_idle("q2_after");

    // Test 5: reset pulse mid-block at j=30
    make_gold(abc_blk);
    load(abc_blk);
    stream(0, 30, "pre_rst");
    chk("pre_rst_idx", w_idx, 30);
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle("async_rst");
    step(); step();
    rst_n = 1'b1;
    step();
    chk_idle("post_rst");
    load(abc_blk);
    stream(0, 64, "rst_abc");
    chk("rst_abc_j17_w", cap_w[17], 32'h000f0000);

    // Test 6: 100 idle cycles
    for (int c = 0; c < 100; c++) begin
      step();
      chk_idle("idle100");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
